dec_rd_scheduler: RTL and testbench
===================================

DEC_RD_SCHEDULER -- requirements
Module: dec_rd_scheduler

Interface
REQ-001 Parameter NUM_DEC, default 2, number of decompressor slots sharing the DMA read channel.
REQ-002 Parameter ADDR_W, default 64, DMA address width.
REQ-003 Parameter MAX_BEATS, default 64, maximum beats per read burst (1..256); beat = 64 bytes.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 job_valid_i  input  1  job load strobe, one cycle.
REQ-007 job_id_i  input  16  target slot index.
REQ-008 job_src_addr_i  input  ADDR_W  source byte address, 64-byte aligned.
REQ-009 job_comp_len_i  input  32  compressed length in bytes.
REQ-010 job_err_o  output  1  one-cycle pulse: job rejected.
REQ-011 dec_almost_empty_i  input  NUM_DEC  per-slot input FIFO wants data.
REQ-012 rd_req  output  1  burst request.
REQ-013 rd_addr  output  ADDR_W  burst start address.
REQ-014 rd_len  output  8  burst beats minus one.
REQ-015 rd_req_ack  input  1  request accepted.
REQ-016 rd_data_valid  input  1  read beat present.
REQ-017 rd_data_taken  input  1  beat consumed by the granted decompressor.
REQ-018 rd_rlast  input  1  last beat of burst.
REQ-019 rd_dec_valid  output  NUM_DEC  one-hot steering of read beats to a slot.
REQ-020 slot_busy_o  output  NUM_DEC  slot has a job in progress.
REQ-021 fetch_done_o  output  NUM_DEC  one-cycle pulse per slot: all input bytes fetched.

Function
REQ-022 Per slot, the block SHALL hold next address and remaining bytes (32 bit); a slot is busy while remaining != 0 or it owns an open burst.
REQ-023 A job SHALL load when job_valid_i=1, job_id_i<NUM_DEC, slot not busy, and job_comp_len_i!=0; slot_busy_o rises the next cycle.
REQ-024 Otherwise job_valid_i SHALL leave state unchanged and pulse job_err_o the next cycle.
REQ-025 A slot is eligible when remaining!=0, dec_almost_empty_i[slot]=1, and it owns no open burst.
REQ-026 The FSM SHALL have states IDLE, REQ, and DATA.
REQ-027 In IDLE with any eligible slot, the block SHALL grant round-robin, searching from (last grant + 1) mod NUM_DEC; reset pointer = slot 0 has highest priority. It then enters REQ.
REQ-028 In REQ, rd_req=1, rd_addr=slot address, rd_len=min(ceil(remaining/64), MAX_BEATS)-1; outputs SHALL hold stable until rd_req_ack.
REQ-029 On rd_req_ack the block SHALL advance address by (rd_len+1)*64, subtract min(remaining, (rd_len+1)*64) from remaining, and enter DATA.
REQ-030 In DATA, rd_dec_valid SHALL equal the one-hot grant. All other states SHALL drive rd_dec_valid=0.
REQ-031 A beat counts only when rd_data_valid & rd_data_taken; on a counted beat with rd_rlast=1 the block SHALL return to IDLE and record the grant as the last grant.
REQ-032 If remaining is 0 at that rlast, fetch_done_o[slot] SHALL pulse the next cycle and slot_busy_o fall.
REQ-033 Grant latency SHALL be 1 cycle: eligibility seen in IDLE at cycle N gives rd_req=1 at cycle N+1.
REQ-034 Back-to-back: the IDLE cycle after rlast is mandatory; there is no grant in the rlast cycle.
REQ-035 dec_almost_empty_i deasserting during REQ or DATA SHALL NOT cancel the burst.
REQ-036 A job load for a slot other than the granted one SHALL be accepted in any state.
REQ-037 A simultaneous job load and rlast for the same slot SHALL be rejected, because the slot is busy in that cycle.
REQ-038 rd_data_valid in IDLE or REQ SHALL be ignored.

Reset
REQ-039 On rst=1 at a clock edge: state IDLE, rd_req=0, rd_addr=0, rd_len=0, rd_dec_valid=0, job_err_o=0, fetch_done_o=0, slot_busy_o=0, all remaining=0, round-robin pointer favours slot 0.
REQ-040 Reset mid-burst SHALL abandon the burst; beats after reset are ignored.

Verification
REQ-041 Load slot0 addr 0x1000, len 200, almost_empty0=1 -> rd_req with rd_addr 0x1000, rd_len 3; after ack and 4 beats, fetch_done_o[0] pulses and slot_busy_o[0]=0.
REQ-042 Load slot0 len 8192 (MAX_BEATS=64) -> two bursts of rd_len 63 at addr A and A+0x1000; fetch_done after the second rlast.
REQ-043 Both slots loaded and both almost_empty held at 1 -> grants alternate 0,1,0,1; rd_dec_valid is 01 and 10 matching the bursts.
REQ-044 job_id_i=5; job to a busy slot; job_comp_len_i=0 -> job_err_o pulses each time and state is unchanged.
REQ-045 rd_req_ack held 0 for 10 cycles -> rd_req, rd_addr, rd_len stable; data_valid with taken=0 does not end the burst.
REQ-046 rst asserted in DATA after 2 of 4 beats -> all outputs at reset values next cycle; later rlast is ignored.

Source files
------------

// File: rtl/dec_rd_scheduler.sv
// rtl/dec_rd_scheduler.sv - round-robin DMA read burst scheduler for decompressor slots
//
// Each decompressor slot holds a job: a next source address and a count of compressed
// bytes still to fetch. Slots whose input FIFO is almost empty compete for the single
// DMA read channel. The winner gets one burst of up to MAX_BEATS 64-byte beats. The
// returning beats are steered to the winner until the last beat of the burst.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   job_valid_i               one-cycle job load strobe
//   job_id_i [15:0]           target slot of the job
//   job_src_addr_i [ADDR_W]   64-byte aligned source address
//   job_comp_len_i [31:0]     compressed length in bytes
//   job_err_o                 one-cycle pulse: the previous job strobe was rejected
//   dec_almost_empty_i [N]    per-slot request for more input data
//   rd_req/rd_addr/rd_len     burst request, start address, beats minus one
//   rd_req_ack                request accepted by the DMA
//   rd_data_valid/taken/rlast read beat handshake and end-of-burst marker
//   rd_dec_valid [N]          one-hot steering of read beats during a burst
//   slot_busy_o [N]           slot has bytes left or owns the open burst
//   fetch_done_o [N]          one-cycle pulse: all of the slot's input bytes fetched

module dec_rd_scheduler #(
  parameter int NUM_DEC   = 2,
  parameter int ADDR_W    = 64,
  parameter int MAX_BEATS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid_i,
  input  logic [15:0]         job_id_i,
  input  logic [ADDR_W-1:0]   job_src_addr_i,
  input  logic [31:0]         job_comp_len_i,
  output logic                job_err_o,
  input  logic [NUM_DEC-1:0]  dec_almost_empty_i,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic [7:0]          rd_len,
  input  logic                rd_req_ack,
  input  logic                rd_data_valid,
  input  logic                rd_data_taken,
  input  logic                rd_rlast,
  output logic [NUM_DEC-1:0]  rd_dec_valid,
  output logic [NUM_DEC-1:0]  slot_busy_o,
  output logic [NUM_DEC-1:0]  fetch_done_o
);

  localparam int IDX_W = (NUM_DEC > 1) ? $clog2(NUM_DEC) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  last_grant;

  logic [ADDR_W-1:0] slot_addr [NUM_DEC];
  logic [31:0]       slot_rem  [NUM_DEC];

  logic [NUM_DEC-1:0] elig;
  logic               any_elig;
  logic [IDX_W-1:0]   next_grant;
  logic [7:0]         next_len;
  logic [32:0]        next_beats;
  int                 cand;

  logic               job_accept;
  logic [IDX_W-1:0]   job_slot;

  logic [8:0]         burst_beats;
  logic [31:0]        burst_bytes;
  logic               beat;

  // A slot stays busy while it owns the open burst even when its remaining count is
  // already zero, so a reload cannot race the tail of that burst.
  always_comb begin
    slot_busy_o = '0;
    elig        = '0;
    for (int s = 0; s < NUM_DEC; s++) begin
      slot_busy_o[s] = (slot_rem[s] != 32'd0) ||
                       ((state != ST_IDLE) && (grant == IDX_W'(s)));
      elig[s]        = (slot_rem[s] != 32'd0) && dec_almost_empty_i[s] &&
                       !((state != ST_IDLE) && (grant == IDX_W'(s)));
    end
  end

  // Round-robin search starting one past the previous grant.
  always_comb begin
    any_elig   = 1'b0;
    next_grant = '0;
    cand       = 0;
    for (int k = 0; k < NUM_DEC; k++) begin
      cand = (int'(last_grant) + 1 + k) % NUM_DEC;
      if (!any_elig && elig[cand]) begin
        any_elig   = 1'b1;
        next_grant = IDX_W'(cand);
      end
    end
  end

  // Burst length: ceil(remaining/64) beats, clipped to MAX_BEATS, encoded minus one.
  // With MAX_BEATS=256 the 8-bit wrap of 0-1 yields the correct 255.
  always_comb begin
    next_beats = ({1'b0, slot_rem[next_grant]} + 33'd63) >> 6;
    if (next_beats > 33'(MAX_BEATS)) begin
      next_len = 8'(MAX_BEATS - 1);
    end else begin
      next_len = next_beats[7:0] - 8'd1;
    end
  end

  assign job_slot   = job_id_i[IDX_W-1:0];
  assign job_accept = job_valid_i && (job_id_i < 16'(NUM_DEC)) &&
                      !slot_busy_o[job_slot] && (job_comp_len_i != 32'd0);

  assign burst_beats = {1'b0, rd_len} + 9'd1;
  assign burst_bytes = {17'd0, burst_beats, 6'd0};
  assign beat        = rd_data_valid && rd_data_taken;

  assign rd_req = (state == ST_REQ);

  always_comb begin
    rd_dec_valid = '0;
    if (state == ST_DATA) begin
      rd_dec_valid[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      grant        <= '0;
      last_grant   <= IDX_W'(NUM_DEC - 1);
      rd_addr      <= '0;
      rd_len       <= '0;
      job_err_o    <= 1'b0;
      fetch_done_o <= '0;
      for (int s = 0; s < NUM_DEC; s++) begin
        slot_addr[s] <= '0;
        slot_rem[s]  <= '0;
      end
    end else begin
      job_err_o    <= job_valid_i && !job_accept;
      fetch_done_o <= '0;

      // An accepted job never targets the granted slot (it is busy), so this write
      // cannot collide with the burst bookkeeping below.
      if (job_accept) begin
        slot_addr[job_slot] <= job_src_addr_i;
        slot_rem[job_slot]  <= job_comp_len_i;
      end

      case (state)
        ST_IDLE: begin
          if (any_elig) begin
            grant   <= next_grant;
            rd_addr <= slot_addr[next_grant];
            rd_len  <= next_len;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_req_ack) begin
            slot_addr[grant] <= slot_addr[grant] + ADDR_W'(burst_bytes);
            slot_rem[grant]  <= (slot_rem[grant] < burst_bytes) ? 32'd0
                                                                : slot_rem[grant] - burst_bytes;
            state            <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat && rd_rlast) begin
            last_grant <= grant;
            state      <= ST_IDLE;
            if (slot_rem[grant] == 32'd0) begin
              fetch_done_o[grant] <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_rd_scheduler.sv
// tb/tb_dec_rd_scheduler.sv - scoreboard bench for dec_rd_scheduler

module tb_dec_rd_scheduler;

  localparam int NUM_DEC = 2;
  localparam int ADDR_W = 64;
  localparam int MAX_B  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              job_valid_i;
  logic [15:0]       job_id_i;
  logic [ADDR_W-1:0] job_src_addr_i;
  logic [31:0]       job_comp_len_i;
  logic              job_err_o;
  logic [1:0]        dec_almost_empty_i;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              rd_req_ack;
  logic              rd_data_valid;
  logic              rd_data_taken;
  logic              rd_rlast;
  logic [1:0]        rd_dec_valid;
  logic [1:0]        slot_busy_o;
  logic [1:0]        fetch_done_o;

  typedef struct {
    int          slot;
    logic [63:0] addr;
    logic [7:0]  len;
    bit          done;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  dec_rd_scheduler #(.NUM_DEC(NUM_DEC), .ADDR_W(ADDR_W), .MAX_BEATS(MAX_B)) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid_i), .job_id_i(job_id_i), .job_src_addr_i(job_src_addr_i),
    .job_comp_len_i(job_comp_len_i), .job_err_o(job_err_o),
    .dec_almost_empty_i(dec_almost_empty_i),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_req_ack(rd_req_ack),
    .rd_data_valid(rd_data_valid), .rd_data_taken(rd_data_taken), .rd_rlast(rd_rlast),
    .rd_dec_valid(rd_dec_valid), .slot_busy_o(slot_busy_o), .fetch_done_o(fetch_done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; job_valid_i = 1'b0; job_id_i = '0; job_src_addr_i = '0; job_comp_len_i = '0;
    dec_almost_empty_i = '0; rd_req_ack = 1'b0; rd_data_valid = 1'b0; rd_data_taken = 1'b0;
    rd_rlast = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic load_job(input int id, input logic [63:0] addr, input logic [31:0] len,
                          output logic err);
    job_valid_i = 1'b1; job_id_i = 16'(id); job_src_addr_i = addr; job_comp_len_i = len;
    tick();
    job_valid_i = 1'b0;
    err = job_err_o;
  endtask

  // Reference split of a job into bursts of at most MAX_B 64-byte beats.
  task automatic push_job(input int slot, input logic [63:0] addr, input longint len);
    exp_t e;
    longint rem = len;
    longint beats;
    logic [63:0] a = addr;
    while (rem > 0) begin
      beats = (rem + 63) / 64;
      if (beats > MAX_B) beats = MAX_B;
      e.slot = slot; e.addr = a; e.len = 8'(beats - 1); e.done = (rem <= beats * 64);
      sb.push_back(e);
      a = a + 64'(beats * 64);
      rem = (rem > beats * 64) ? rem - beats * 64 : 0;
    end
  endtask

  // Waits for the next request, compares it with the scoreboard head, then acknowledges
  // and returns all beats. stall holds the ack off; junk adds beats that must be ignored.
  task automatic serve_burst(input int stall, input bit junk);
    exp_t e;
    int n = 0;
    logic [1:0] oh;
    logic [1:0] ae_save;
    while (rd_req !== 1'b1 && n < 50) begin tick(); n++; end
    total++;
    if (rd_req !== 1'b1) begin bad++; $display("FAIL req_timeout: rd_req=%b want 1", rd_req); return; end
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL sb_empty: unexpected request addr=%h", rd_addr); return; end
    e = sb.pop_front();
    oh = 2'b01 << e.slot;
    total++; if (rd_addr !== e.addr) begin bad++; $display("FAIL req_addr: got %h want %h", rd_addr, e.addr); end
    total++; if (rd_len !== e.len) begin bad++; $display("FAIL req_len: got %0d want %0d", rd_len, e.len); end
    total++; if (rd_dec_valid !== 2'b00) begin bad++; $display("FAIL req_decv: got %b want 00", rd_dec_valid); end
    for (int i = 0; i < stall; i++) begin
      rd_data_valid = junk; rd_data_taken = junk; rd_rlast = junk;
      tick();
      total++;
      if (rd_req !== 1'b1 || rd_addr !== e.addr || rd_len !== e.len) begin
        bad++; $display("FAIL stall_hold: req=%b addr=%h len=%0d want 1 %h %0d", rd_req, rd_addr, rd_len, e.addr, e.len);
      end
    end
    rd_data_valid = 1'b0; rd_data_taken = 1'b0; rd_rlast = 1'b0;
    rd_req_ack = 1'b1;
    tick();
    rd_req_ack = 1'b0;
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL ack_req: rd_req=%b want 0", rd_req); end
    total++; if (rd_dec_valid !== oh) begin bad++; $display("FAIL data_decv: got %b want %b", rd_dec_valid, oh); end
    if (junk) begin
      ae_save = dec_almost_empty_i;
      dec_almost_empty_i = 2'b00;
      rd_data_valid = 1'b1; rd_data_taken = 1'b0; rd_rlast = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        total++; if (rd_dec_valid !== oh) begin bad++; $display("FAIL untaken_beat: decv=%b want %b", rd_dec_valid, oh); end
      end
      dec_almost_empty_i = ae_save;
    end
    for (int b = 0; b <= int'(e.len); b++) begin
      rd_data_valid = 1'b1; rd_data_taken = 1'b1; rd_rlast = (b == int'(e.len));
      tick();
    end
    rd_data_valid = 1'b0; rd_data_taken = 1'b0; rd_rlast = 1'b0;
    total++; if (fetch_done_o !== (e.done ? oh : 2'b00)) begin bad++; $display("FAIL fetch_done: got %b want %b", fetch_done_o, e.done ? oh : 2'b00); end
    total++; if (rd_dec_valid !== 2'b00 || rd_req !== 1'b0) begin bad++; $display("FAIL post_rlast_idle: decv=%b req=%b want 00 0", rd_dec_valid, rd_req); end
    if (e.done) begin
      total++; if (slot_busy_o[e.slot] !== 1'b0) begin bad++; $display("FAIL busy_fall: slot %0d busy=%b want 0", e.slot, slot_busy_o[e.slot]); end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({rd_req, rd_addr, rd_len, rd_dec_valid, job_err_o, fetch_done_o, slot_busy_o} !== '0) begin
      bad++; $display("FAIL reset_outputs: req=%b addr=%h len=%0d decv=%b err=%b done=%b busy=%b want all 0",
                      rd_req, rd_addr, rd_len, rd_dec_valid, job_err_o, fetch_done_o, slot_busy_o);
    end
  endtask

  task automatic test_basic();
    logic err;
    do_reset();
    dec_almost_empty_i = 2'b01;
    push_job(0, 64'h1000, 200);
    load_job(0, 64'h1000, 200, err);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err); end
    total++; if (slot_busy_o !== 2'b01) begin bad++; $display("FAIL basic_busy: got %b want 01", slot_busy_o); end
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL latency_early: rd_req=%b want 0", rd_req); end
    tick();
    total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL latency_one: rd_req=%b want 1", rd_req); end
    serve_burst(0, 1'b0);
    tick();
    total++; if (fetch_done_o !== 2'b00) begin bad++; $display("FAIL done_pulse: got %b want 00", fetch_done_o); end
  endtask

  task automatic test_two_bursts();
    logic err;
    do_reset();
    dec_almost_empty_i = 2'b01;
    push_job(0, 64'h40000, 8192);
    load_job(0, 64'h40000, 8192, err);
    serve_burst(0, 1'b0);
    serve_burst(0, 1'b0);
  endtask

  task automatic test_alternate();
    logic err;
    exp_t e;
    do_reset();
    dec_almost_empty_i = 2'b11;
    e.slot = 0; e.addr = 64'h10000; e.len = 8'd63; e.done = 1'b0; sb.push_back(e);
    e.slot = 1; e.addr = 64'h20000; e.len = 8'd63; e.done = 1'b0; sb.push_back(e);
    e.slot = 0; e.addr = 64'h11000; e.len = 8'd0;  e.done = 1'b1; sb.push_back(e);
    e.slot = 1; e.addr = 64'h21000; e.len = 8'd0;  e.done = 1'b1; sb.push_back(e);
    load_job(0, 64'h10000, 4160, err);
    load_job(1, 64'h20000, 4160, err);
    for (int i = 0; i < 4; i++) serve_burst(0, 1'b0);
  endtask

  task automatic test_errors();
    logic err;
    do_reset();
    load_job(5, 64'h8000, 64, err);
    total++; if (err !== 1'b1 || slot_busy_o !== 2'b00) begin bad++; $display("FAIL err_bad_id: err=%b busy=%b want 1 00", err, slot_busy_o); end
    load_job(1, 64'h8000, 0, err);
    total++; if (err !== 1'b1 || slot_busy_o !== 2'b00) begin bad++; $display("FAIL err_zero_len: err=%b busy=%b want 1 00", err, slot_busy_o); end
    push_job(0, 64'h3000, 200);
    load_job(0, 64'h3000, 200, err);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_good_load: err=%b want 0", err); end
    load_job(0, 64'h9000, 64, err);
    total++; if (err !== 1'b1 || slot_busy_o !== 2'b01 || rd_req !== 1'b0) begin bad++; $display("FAIL err_busy_slot: err=%b busy=%b req=%b want 1 01 0", err, slot_busy_o, rd_req); end
    tick();
    total++; if (job_err_o !== 1'b0) begin bad++; $display("FAIL err_pulse: err=%b want 0", job_err_o); end
    dec_almost_empty_i = 2'b01;
    serve_burst(0, 1'b0);
  endtask

  task automatic test_stall();
    logic err;
    do_reset();
    dec_almost_empty_i = 2'b10;
    push_job(1, 64'h2000, 64);
    load_job(1, 64'h2000, 64, err);
    serve_burst(10, 1'b1);
  endtask

  task automatic test_job_during_data();
    logic err;
    int n = 0;
    do_reset();
    dec_almost_empty_i = 2'b01;
    load_job(0, 64'h6000, 64, err);
    while (rd_req !== 1'b1 && n < 50) begin tick(); n++; end
    total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL jdd_req: rd_req=%b want 1", rd_req); end
    rd_req_ack = 1'b1; tick(); rd_req_ack = 1'b0;
    load_job(1, 64'h7000, 128, err);
    total++; if (err !== 1'b0 || slot_busy_o !== 2'b11) begin bad++; $display("FAIL jdd_other_slot: err=%b busy=%b want 0 11", err, slot_busy_o); end
    job_valid_i = 1'b1; job_id_i = 16'd0; job_src_addr_i = 64'hA000; job_comp_len_i = 64;
    rd_data_valid = 1'b1; rd_data_taken = 1'b1; rd_rlast = 1'b1;
    tick();
    job_valid_i = 1'b0; rd_data_valid = 1'b0; rd_data_taken = 1'b0; rd_rlast = 1'b0;
    total++; if (job_err_o !== 1'b1 || fetch_done_o !== 2'b01 || slot_busy_o !== 2'b10) begin
      bad++; $display("FAIL jdd_rlast_load: err=%b done=%b busy=%b want 1 01 10", job_err_o, fetch_done_o, slot_busy_o);
    end
    dec_almost_empty_i = 2'b10;
    push_job(1, 64'h7000, 128);
    serve_burst(0, 1'b0);
    total++; if (slot_busy_o !== 2'b00) begin bad++; $display("FAIL jdd_final_busy: got %b want 00", slot_busy_o); end
  endtask

  task automatic test_reset_mid();
    logic err;
    int n = 0;
    do_reset();
    dec_almost_empty_i = 2'b01;
    load_job(0, 64'h5000, 256, err);
    while (rd_req !== 1'b1 && n < 50) begin tick(); n++; end
    total++; if (rd_req !== 1'b1 || rd_len !== 8'd3) begin bad++; $display("FAIL rmid_req: req=%b len=%0d want 1 3", rd_req, rd_len); end
    rd_req_ack = 1'b1; tick(); rd_req_ack = 1'b0;
    rd_data_valid = 1'b1; rd_data_taken = 1'b1;
    tick(); tick();
    rd_data_valid = 1'b0; rd_data_taken = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({rd_req, rd_addr, rd_len, rd_dec_valid, job_err_o, fetch_done_o, slot_busy_o} !== '0) begin
      bad++; $display("FAIL rmid_outputs: req=%b addr=%h len=%0d decv=%b err=%b done=%b busy=%b want all 0",
                      rd_req, rd_addr, rd_len, rd_dec_valid, job_err_o, fetch_done_o, slot_busy_o);
    end
    rd_data_valid = 1'b1; rd_data_taken = 1'b1;
    tick();
    rd_rlast = 1'b1;
    tick();
    rd_data_valid = 1'b0; rd_data_taken = 1'b0; rd_rlast = 1'b0;
    tick();
    total++;
    if ({rd_req, rd_dec_valid, fetch_done_o, slot_busy_o} !== '0) begin
      bad++; $display("FAIL rmid_late_rlast: req=%b decv=%b done=%b busy=%b want all 0", rd_req, rd_dec_valid, fetch_done_o, slot_busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_bursts();
    test_alternate();
    test_errors();
    test_stall();
    test_job_during_data();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: %0d entries want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
